// File: rtl/ofdm_rx_frame_ctrl.sv
// ofdm_rx_frame_ctrl
// Receive-side frame sequencer. It follows the preamble A -> preamble B sequence.
// It then opens the sample gate into CP removal for the programmed number of
// payload symbols. It also reports frame sync, frame done, a missed preamble B
// (timeout), and FFT back-pressure overrun.
module ofdm_rx_frame_ctrl #(
  parameter int SYMBOLS_SIZE = 256,
  parameter int CP_LENGHT    = 8,
  parameter int NSYM_W       = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic              i_find_preamble_a,
  input  logic              i_find_preamble_b,
  input  logic [NSYM_W-1:0] i_num_symbols,
  input  logic              i_fft_wayt_data,
  output logic              o_sample_valid,
  output logic              o_frame_sync,
  output logic              o_busy,
  output logic [1:0]        o_state,
  output logic [NSYM_W-1:0] o_symbol_cnt,
  output logic              o_frame_done,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int SYM_LEN = SYMBOLS_SIZE + CP_LENGHT;
  localparam int SAMP_W  = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [NSYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [NSYM_W-1:0]   nsym_lat_q, nsym_lat_d;
  logic                frame_sync_q, frame_sync_d;
  logic                frame_done_q, frame_done_d;
  logic                timeout_q, timeout_d;
  logic                overrun_q, overrun_d;

  logic qual;
  logic accept;

  assign qual   = i_en & i_valid;
  assign accept = (state_q == ST_PAYLOAD) & qual & i_fft_wayt_data;

  // Next-state and counter logic; pulses default low so they last one cycle.
  // While the block is disabled, every register holds its value.
  always_comb begin
    state_d      = state_q;
    samp_cnt_d   = samp_cnt_q;
    to_cnt_d     = to_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    nsym_lat_d   = nsym_lat_q;
    frame_sync_d = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;

    if (i_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_find_preamble_a) begin
            state_d  = ST_WAIT_B;
            to_cnt_d = '0;
          end
        end

        ST_WAIT_B: begin
          if (i_find_preamble_a) begin
            to_cnt_d = '0;
          end else if (i_find_preamble_b) begin
            state_d      = ST_PAYLOAD;
            samp_cnt_d   = '0;
            sym_cnt_d    = '0;
            nsym_lat_d   = (i_num_symbols == '0) ? NSYM_W'(1) : i_num_symbols;
            frame_sync_d = 1'b1;
          end else if (qual) begin
            if (to_cnt_q == TO_LAST) begin
              timeout_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
        end

        ST_PAYLOAD: begin
          if (i_find_preamble_a) begin
            state_d  = ST_WAIT_B;
            to_cnt_d = '0;
          end else if (qual && !i_fft_wayt_data) begin
            overrun_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (accept) begin
            if (samp_cnt_q == SAMP_LAST) begin
              samp_cnt_d = '0;
              if (sym_cnt_q == (nsym_lat_q - NSYM_W'(1))) begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
              end else begin
                sym_cnt_d = sym_cnt_q + NSYM_W'(1);
              end
            end else begin
              samp_cnt_d = samp_cnt_q + SAMP_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered pulses; reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      samp_cnt_q   <= '0;
      to_cnt_q     <= '0;
      sym_cnt_q    <= '0;
      nsym_lat_q   <= '0;
      frame_sync_q <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      to_cnt_q     <= to_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      nsym_lat_q   <= nsym_lat_d;
      frame_sync_q <= frame_sync_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_sample_valid = accept;
  assign o_frame_sync   = frame_sync_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_state        = state_q;
  assign o_symbol_cnt   = sym_cnt_q;
  assign o_frame_done   = frame_done_q;
  assign o_timeout      = timeout_q;
  assign o_overrun      = overrun_q;

endmodule

// File: doc/ofdm_rx_frame_ctrl.md
# ofdm_rx_frame_ctrl

Receive-side frame sequencer for the OFDM receiver. It sits between the two preamble detectors (A and B) and the cyclic-prefix-removal / FFT datapath. It tracks the preamble A → preamble B sequence and opens the sample gate into CP removal for exactly the programmed number of payload symbols. It also issues the frame-sync pulse, times out a missing preamble B, and aborts on FFT back-pressure overrun.

## Interface
Parameters:
- SYMBOLS_SIZE, 256, FFT length in samples
- CP_LENGHT, 8, cyclic-prefix length in samples
- NSYM_W, 8, width of symbol-count fields
- TIMEOUT, 1024, qualified samples allowed between preamble A and preamble B

Ports:
- i_clk  in  1  sole clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  block enable; qualifies all inputs
- i_valid  in  1  input sample strobe
- i_find_preamble_a  in  1  preamble A detector hit (single-cycle)
- i_find_preamble_b  in  1  preamble B detector hit (single-cycle)
- i_num_symbols  in  NSYM_W  payload symbols per frame; sampled when B is detected
- i_fft_wayt_data  in  1  FFT ready to accept samples
- o_sample_valid  out  1  gated valid to CP removal
- o_frame_sync  out  1  one-cycle pulse at payload start
- o_busy  out  1  state ≠ IDLE
- o_state  out  2  0 = IDLE, 1 = WAIT_B, 2 = PAYLOAD
- o_symbol_cnt  out  NSYM_W  index of the current payload symbol
- o_frame_done  out  1  one-cycle pulse when the last symbol completes
- o_timeout  out  1  one-cycle pulse when preamble B is missed
- o_overrun  out  1  one-cycle pulse when a sample arrives while the FFT is not ready

## Operation
- Qualifier: q = i_en & i_valid. The detector inputs count only when i_en = 1.
- Internal registers:
  - samp_cnt, ceil(log2(SYMBOLS_SIZE+CP_LENGHT)) bits
  - to_cnt, ceil(log2(TIMEOUT)) bits
  - sym_cnt, NSYM_W bits
  - nsym_lat, NSYM_W bits
- IDLE:
  - On A: go to WAIT_B and set to_cnt = 0.
  - B alone is ignored.
- WAIT_B, rules in priority order:
  1. A → stay in WAIT_B and clear to_cnt (resync).
  2. B → go to PAYLOAD. Clear samp_cnt and sym_cnt. Latch nsym_lat = i_num_symbols; a value of 0 is treated as 1. Pulse o_frame_sync.
  3. q with to_cnt == TIMEOUT-1 → pulse o_timeout and go to IDLE.
  4. q otherwise → to_cnt + 1.
- PAYLOAD:
  - o_sample_valid = q & i_fft_wayt_data. This is combinational from the registered state.
  - A → go to WAIT_B and clear to_cnt. No frame_done is issued.
  - q & ~i_fft_wayt_data → pulse o_overrun and go to IDLE. The sample is dropped.
  - Accepted sample:
    - If samp_cnt == SYMBOLS_SIZE+CP_LENGHT-1, wrap samp_cnt to 0.
    - If in addition sym_cnt == nsym_lat-1, pulse o_frame_done and go to IDLE.
    - Otherwise the wrap increments sym_cnt.
  - B in PAYLOAD is ignored.
- i_en = 0 freezes all counters and the state. Detector hits are ignored while i_en = 0.
- o_symbol_cnt = sym_cnt. It holds its final value after the frame until the next B.

## Timing
- Reset (async assert, sync release): state IDLE and all counters 0. Every output is 0: o_state = 0, o_busy = 0, o_symbol_cnt = 0, all pulses 0.
- All outputs are registered except o_sample_valid. Pulses last exactly one cycle.
- o_frame_sync is high in the first cycle that o_state = 2. A sample accepted in that same cycle is the first CP sample of symbol 0, so the downstream block must honour sync and valid together.
- State latency: a detector hit or the terminating sample at edge N is visible on o_state after edge N.
- o_frame_done and o_overrun are asserted in the cycle after the triggering sample. o_sample_valid is already 0 in that cycle.
- o_timeout is asserted in the cycle after the TIMEOUT-th qualified sample following A.
- Reset asserted mid-PAYLOAD forces o_sample_valid low immediately (asynchronously) and suppresses any pending pulse.
- Per frame, o_sample_valid is high for nsym_lat × (SYMBOLS_SIZE+CP_LENGHT) qualified cycles.

## Test plan
- Normal frame: A, 10 samples, B with i_num_symbols = 2, then 528 continuous samples with FFT ready. Required: o_frame_sync once, o_sample_valid high for 528 cycles, o_symbol_cnt goes 0→1 after sample 264, o_frame_done one cycle after sample 528, then o_state = 0.
- Gapped input: same frame with i_valid toggling 1/0 and i_en low for 50 cycles mid-symbol. Required: exactly 528 gated samples and counters frozen during the gaps.
- Timeout: A followed by 1024 qualified samples with no B. Required: o_timeout after the 1024th sample, o_state = 0; a B arriving later is ignored.
- Overrun: in PAYLOAD, symbol 0, sample 100, drop i_fft_wayt_data with i_valid = 1. Required: o_overrun pulse, o_sample_valid = 0 for that sample, o_state = 0, and no o_frame_done.
- Resync: A at PAYLOAD sample 300, followed by B. Required: o_state goes 2→1→2, a second o_frame_sync, sym_cnt restarts at 0, and the full frame length is counted again.
- Reset mid-PAYLOAD: drive i_reset_n low between clock edges. Required: all outputs go to 0 before the next edge; after release the block stays in IDLE until a new A.
